result_display_8bit: RTL and testbench

RESULT_DISPLAY_8BIT -- requirements
Module: result_display_8bit

---
 rtl/result_display_8bit_pkg.sv | 34 +++
 rtl/result_display_8bit_bin2bcd.sv | 55 +++++
 rtl/result_display_8bit.sv | 140 ++++++++++++++
 tb/tb_result_display_8bit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_8bit_pkg.sv
// Shared definitions for the result display block.
//   - FSM state encoding (IDLE, CONVERT, LOAD)
//   - active-low seven-segment patterns {g,f,e,d,c,b,a}: digits, blank, minus
//   - default scan refresh width
package result_display_8bit_pkg;

  localparam int REFRESH_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/result_display_8bit_bin2bcd.sv
// bin2bcd_8bit: sequential double-dabble, one shift per cycle.
// Ports:
//   clk, reset       clock / async active-high reset (abandons a conversion)
//   start            load bin and begin; 8 shifts follow on the next 8 edges
//   bin[7:0]         unsigned binary input
//   done             high during the cycle that performs the final shift;
//                    hund/tens/units are valid from the following cycle
//   hund,tens,units  BCD result nibbles
module bin2bcd_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // {hund, tens, units, binary remainder}
  logic [19:0] sh;
  logic [19:0] adj;
  logic [2:0]  cnt;
  logic        run;

  // add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    adj = sh;
    if (sh[11:8]  >= 4'd5) adj[11:8]  = sh[11:8]  + 4'd3;
    if (sh[15:12] >= 4'd5) adj[15:12] = sh[15:12] + 4'd3;
    if (sh[19:16] >= 4'd5) adj[19:16] = sh[19:16] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= {12'd0, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sh  <= {adj[18:0], 1'b0};
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) run <= 1'b0;
    end
  end

  assign done  = run && (cnt == 3'd7);
  assign hund  = sh[19:16];
  assign tens  = sh[15:12];
  assign units = sh[11:8];

endmodule

// File: rtl/result_display_8bit.sv
// result_display_8bit: latches calculator results, converts them to BCD and
// scans them onto a 4-digit active-low seven-segment display.
// Ports:
//   clk, reset   clock / async active-high reset
//   result[7:0]  value to display, valid when ready=1
//   ready        sample strobe; samples queue one-deep, newest wins
//   seg[6:0]     registered active-low segments {g,f,e,d,c,b,a}
//   an[3:0]      registered active-low anodes, an[0] = rightmost digit
//   busy         high while a conversion or display load is in flight
// Build option: define SIGNED_DISPLAY_EN to show result as two's complement
// with a minus sign on digit 3; otherwise unsigned 0..255, digit 3 blank.
module result_display_8bit
  import result_display_8bit_pkg::*;
#(
  parameter int REFRESH_BITS = REFRESH_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] result,
  input  logic       ready,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [REFRESH_BITS-1:0] SCNT_ONE = 1;

  state_t      state;
  logic        pend;
  logic [7:0]  pend_val;
  logic        start;
  logic        is_neg;
  logic [7:0]  mag;
  logic        conv_neg;
  logic        done;
  logic [3:0]  bh, bt, bu;
  logic [3:0]  dh, dt, du;
  logic        disp_neg;
  logic [REFRESH_BITS-1:0] scnt;
  logic [1:0]  idx;
  logic [6:0]  seg_nxt;

`ifdef SIGNED_DISPLAY_EN
  // magnitude of -128 is 128, which still fits the unsigned converter
  assign is_neg = pend_val[7];
  assign mag    = is_neg ? (~pend_val + 8'd1) : pend_val;
`else
  assign is_neg = 1'b0;
  assign mag    = pend_val;
`endif

  // a queued value is consumed from IDLE, or straight out of LOAD
  assign start = pend && ((state == IDLE) || (state == LOAD));

  bin2bcd_8bit u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (mag),
    .done  (done),
    .hund  (bh),
    .tens  (bt),
    .units (bu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
      conv_neg <= 1'b0;
      dh       <= '0;
      dt       <= '0;
      du       <= '0;
      disp_neg <= 1'b0;
    end else begin
      // a fresh sample beats consumption so it is never lost
      if (ready) begin
        pend     <= 1'b1;
        pend_val <= result;
      end else if (start) begin
        pend     <= 1'b0;
      end
      if (start) conv_neg <= is_neg;

      case (state)
        IDLE: if (pend) begin
          state <= CONVERT;
          busy  <= 1'b1;
        end
        CONVERT: if (done) state <= LOAD;
        LOAD: begin
          // only place the visible digits change
          dh       <= bh;
          dt       <= bt;
          du       <= bu;
          disp_neg <= conv_neg;
          if (pend) begin
            state <= CONVERT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // leading-zero blanking; units always shown
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (idx)
      2'd0: seg_nxt = seg_digit(du);
      2'd1: seg_nxt = (dh == 4'd0 && dt == 4'd0) ? SEG_BLANK : seg_digit(dt);
      2'd2: seg_nxt = (dh == 4'd0) ? SEG_BLANK : seg_digit(dh);
      2'd3: seg_nxt = disp_neg ? SEG_MINUS : SEG_BLANK;
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt <= '0;
      idx  <= '0;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
    end else begin
      scnt <= scnt + SCNT_ONE;
      if (&scnt) idx <= idx + 2'd1;
      an   <= ~(4'b0001 << idx);
      seg  <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_result_display_8bit.sv
// Self-checking bench for result_display_8bit (REFRESH_BITS=2).
module tb_result_display_8bit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] result;
  logic       ready;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int errs   = 0;
  int checks = 0;

  logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  result_display_8bit #(.REFRESH_BITS(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .result (result),
    .ready  (ready),
    .seg    (seg),
    .an     (an),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected {digit3,digit2,digit1,digit0} from plain decimal arithmetic
  function automatic logic [27:0] exp_disp(input int v);
    int s, m, h, t, u;
    logic [6:0] d3, d2, d1, d0;
    s = v;
`ifdef SIGNED_DISPLAY_EN
    if (v >= 128) s = v - 256;
`endif
    m  = (s < 0) ? -s : s;
    h  = m / 100;
    t  = (m / 10) % 10;
    u  = m % 10;
    d0 = pat[u];
    d1 = (h == 0 && t == 0) ? 7'h7F : pat[t];
    d2 = (h == 0) ? 7'h7F : pat[h];
    d3 = (s < 0) ? 7'h3F : 7'h7F;
    return {d3, d2, d1, d0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    result = v;
    ready  = 1'b1;
    step();
    ready  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) step();
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // one full scan, collecting the segment pattern seen on each anode
  task automatic read_disp(output logic [27:0] d);
    d = 'x;
    step();
    repeat (16) begin
      step();
      case (an)
        4'b1110: d[6:0]   = seg;
        4'b1101: d[13:7]  = seg;
        4'b1011: d[20:14] = seg;
        4'b0111: d[27:21] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic show(input string tag, input int v);
    logic [27:0] d;
    send(8'(v));
    wait_idle();
    read_disp(d);
    chk(tag, 32'(d), 32'(exp_disp(v)));
  endtask

  initial begin
    logic [27:0] d;
    logic [7:0]  last;
    int n, lows, bad200;

    reset  = 1'b1;
    ready  = 1'b0;
    result = '0;
    repeat (3) step();
    chk("rst_an",   32'(an),   32'hF);
    chk("rst_seg",  32'(seg),  32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);

    // first scan after release: digit 0 shows "0", the rest blank
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("scan_an%0d", k),  32'(an),  32'(~(4'b0001 << (k / 4)) & 4'hF));
      chk($sformatf("scan_seg%0d", k), 32'(seg), (k < 4) ? 32'h40 : 32'h7F);
    end

    // busy spans 8 CONVERT + 1 LOAD cycles
    send(8'd137);
    chk("busy_lat", 32'(busy), 32'd0);
    n = 0;
    step();
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk("busy_len", 32'(n), 32'd9);
    read_disp(d);
    chk("disp137", 32'(d), 32'(exp_disp(137)));

    show("disp7",   7);
    show("disp0",   0);
    show("dispF6",  8'hF6);
    show("disp80",  8'h80);
    show("disp255", 255);

    // reset in the middle of a conversion
    send(8'd99);
    repeat (3) step();
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_an",   32'(an),   32'hF);
    chk("mid_rst_seg",  32'(seg),  32'h7F);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    lows = 0;
    repeat (20) begin
      step();
      if (busy) lows++;
    end
    chk("post_rst_busy", 32'(lows), 32'd0);
    read_disp(d);
    chk("post_rst_disp", 32'(d), 32'(exp_disp(0)));

    // 5, then 200 and 42 while busy: 200 is overwritten and never shown
    send(8'd5);
    n = 0;
    bad200 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin result = 8'd200; ready = 1'b1; end
      if (c == 4) ready = 1'b0;
      if (c == 6) begin result = 8'd42; ready = 1'b1; end
      if (c == 7) ready = 1'b0;
      step();
      if (busy) n++;
      if (an == 4'b1011 && seg != 7'h7F) bad200++;
    end
    chk("queue_busy_len", 32'(n), 32'd18);
    chk("no_200_shown",   32'(bad200), 32'd0);
    read_disp(d);
    chk("disp42", 32'(d), 32'(exp_disp(42)));

    // ready held high: back-to-back conversions, latest value shown
    lows = 0;
    last = '0;
    for (int i = 0; i < 25; i++) begin
      last   = 8'($urandom_range(0, 255));
      result = last;
      ready  = 1'b1;
      step();
      if (i >= 1 && !busy) lows++;
    end
    ready = 1'b0;
    chk("cont_busy", 32'(lows), 32'd0);
    wait_idle();
    read_disp(d);
    chk("cont_disp", 32'(d), 32'(exp_disp(int'(last))));

    // randomized single and overwritten transactions
    for (int i = 0; i < 20; i++) begin
      last = 8'($urandom_range(0, 255));
      send(last);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 7)) step();
        last = 8'($urandom_range(0, 255));
        send(last);
      end
      wait_idle();
      read_disp(d);
      chk($sformatf("rand%0d_v%0d", i, last), 32'(d), 32'(exp_disp(int'(last))));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
